uart_rx_fifo_ctrl: RTL
======================

Name: uart_rx_fifo_ctrl

Overview:
- Controller between the UART receiver datapath and the APB register file.
- Accepts each completed character (data plus PE/FE/BI flags) on the receiver's load strobe, buffers it in a receive FIFO (16550 style), and sequences reads through the RBR.
- Generates line-status bits (DR, OE, PE, FE, BI, RXFE), the trigger-level indication and the character-timeout indication consumed by the interrupt controller.
- With fifo_en=0 it behaves as a single holding register.

Parameters:
- DEPTH, 16, receive FIFO entries; power of 2, at least 2.
- AW, $clog2(DEPTH), pointer width. Derived; do not override.

Ports:
- pclk  input  1  APB/UART clock; all logic on the rising edge.
- utrrst  input  1  synchronous, active-high reset.
- fifo_en  input  1  FCR FIFO enable; 0 selects holding-register mode.
- fifo_clear  input  1  one-cycle pulse; empties the FIFO.
- rx_trigger  input  2  trigger level select: 00→1, 01→4, 10→8, 11→14.
- wls  input  2  word length select (5+wls bits).
- pen  input  1  parity enable.
- stb  input  1  stop bits select (0→1, 1→2).
- receive_load_en  input  1  one-cycle strobe: a character is complete.
- rsr_data  input  8  received character.
- parity_error  input  1  PE for the loaded character.
- frame_error  input  1  FE for the loaded character.
- uart_break  input  1  BI for the loaded character.
- bit_tick  input  1  one pulse per bit period.
- rbr_rd  input  1  one-cycle RBR read strobe.
- lsr_rd  input  1  one-cycle LSR read strobe.
- rbr_data  output  8  FIFO head data.
- data_ready  output  1  LSR[0]: FIFO not empty.
- overrun_error  output  1  LSR[1], sticky.
- lsr_pe  output  1  LSR[2].
- lsr_fe  output  1  LSR[3].
- lsr_bi  output  1  LSR[4].
- rx_fifo_error  output  1  LSR[7].
- rx_fifo_count  output  AW+1  current number of entries.
- rx_trigger_hit  output  1  RDA interrupt condition.
- char_timeout  output  1  CTI interrupt condition.

Behaviour:
- Reset (utrrst=1, or fifo_clear=1 for FIFO state only): pointers, count, error counter and timeout counter go to 0. char_timeout=0.
- Outputs after reset: rbr_data=0x00, data_ready=0, lsr_pe/fe/bi=0, rx_fifo_error=0, rx_trigger_hit=0, rx_fifo_count=0.
- overrun_error is cleared only by utrrst or lsr_rd; fifo_clear does not clear it.
- Storage per entry: {bi, fe, pe, data[7:0]}.
- On a load with uart_break=1, data is forced to 0x00.
- Effective depth: DEPTH when fifo_en=1, otherwise 1.
- Toggling fifo_en performs an implicit clear in the same cycle.
- Write on receive_load_en:
  - Not full: store the entry at wr_ptr and increment. Pointers wrap modulo DEPTH.
  - Full, FIFO mode: discard the character, set overrun_error, FIFO unchanged.
  - Full, holding mode: overwrite the single entry and set overrun_error.
- Read on rbr_rd with count>0: advance rd_ptr. rbr_rd when empty has no effect.
- Read and write in the same cycle:
  - Count is unchanged; no overrun even when full (the read frees the slot first).
  - When empty, the write occurs and the read is ignored.
- rbr_data, lsr_pe, lsr_fe, lsr_bi are combinational from the head entry, masked to 0 when empty. They update in the cycle after a read.
- rx_fifo_error = (count of stored entries with any of pe/fe/bi set) != 0, tracked by an error counter:
  - +1 on an accepted errored write.
  - −1 on a read of an errored head.
  - Net 0 when both happen in the same cycle.
- lsr_rd in the same cycle as an overrun event leaves overrun_error=1 (set wins).
- rx_trigger_hit:
  - FIFO mode: rx_fifo_count >= level.
  - Holding mode: equals data_ready.
- Character timeout:
  - Active only in FIFO mode with count>0.
  - Limit = 4 × frame_bits, where frame_bits = 1 + (5+wls) + pen + (1+stb), giving a range of 28..48.
  - A 6-bit counter clears on receive_load_en, on rbr_rd, or when count==0, and otherwise increments on bit_tick.
  - char_timeout is set when the counter reaches the limit. It holds (counter saturates) until the counter clears.
- All state updates are registered; there is no combinational path from rbr_rd to data_ready other than via registered state.

Test Plan:
- Reset, then 3 loads (0x41, 0x42, 0x43) with fifo_en=1 → count=3, data_ready=1, rbr_data=0x41. After 3 rbr_rd, data reads 0x41, 0x42, 0x43 in order, then count=0 and data_ready=0.
- Fill 16 entries, then a 17th load 0x99 → overrun_error=1, count=16, 0x99 never read. lsr_rd clears OE. Load and rbr_rd in the same cycle while full → count stays 16, OE stays 0.
- Load 0x10 with PE=1, then 0x20 clean → rx_fifo_error=1 and lsr_pe=1 at head. After the first read: lsr_pe=0, rx_fifo_error=0, rbr_data=0x20.
- Load with uart_break=1 and rsr_data=0x5A → rbr_data=0x00, lsr_bi=1.
- rx_trigger=01 → rx_trigger_hit rises exactly on the 4th load and falls on the next read.
- wls=3, pen=1, stb=0 (limit 44), one character held, no reads → char_timeout=1 on the 44th bit_tick, cleared by rbr_rd.
- fifo_en=0, two loads without a read → rbr_data=second char, overrun_error=1, count=1.

Source files
------------

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive-side buffer between the UART receiver datapath and the APB register file.
// Stores completed characters with their PE/FE/BI flags in a 16550-style FIFO. With
// fifo_en=0 it acts as a single holding register.
//
// Latency: a load or read updates state on the next rising edge of pclk. The head
// data and head flags are decoded combinationally from registered state, so a read
// becomes visible in the cycle after the strobe.
//
// Backpressure: there is none. A load into a full FIFO is dropped and sets
// overrun_error. A load into a full holding register overwrites the stored character
// and also sets overrun_error.
//
// Ports:
//   pclk, utrrst              clock, synchronous active-high reset
//   fifo_en, fifo_clear       FCR controls (mode select, one-cycle clear pulse)
//   rx_trigger                RDA trigger level select (1/4/8/14 entries)
//   wls, pen, stb             frame format, used to size the character timeout
//   receive_load_en           one-cycle strobe for a completed character
//   rsr_data                  received character
//   parity_error, frame_error, uart_break
//                             status flags for the completed character
//   bit_tick                  one pulse per bit period
//   rbr_rd, lsr_rd            register read strobes
//   rbr_data                  head data (0 when empty)
//   data_ready .. rx_fifo_error
//                             line status bits
//   rx_fifo_count             current number of stored entries
//   rx_trigger_hit            RDA interrupt condition
//   char_timeout              CTI interrupt condition

module uart_rx_fifo_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          pclk,
  input  logic          utrrst,
  input  logic          fifo_en,
  input  logic          fifo_clear,
  input  logic [1:0]    rx_trigger,
  input  logic [1:0]    wls,
  input  logic          pen,
  input  logic          stb,
  input  logic          receive_load_en,
  input  logic [7:0]    rsr_data,
  input  logic          parity_error,
  input  logic          frame_error,
  input  logic          uart_break,
  input  logic          bit_tick,
  input  logic          rbr_rd,
  input  logic          lsr_rd,
  output logic [7:0]    rbr_data,
  output logic          data_ready,
  output logic          overrun_error,
  output logic          lsr_pe,
  output logic          lsr_fe,
  output logic          lsr_bi,
  output logic          rx_fifo_error,
  output logic [AW:0]   rx_fifo_count,
  output logic          rx_trigger_hit,
  output logic          char_timeout
);

  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef struct packed {
    logic       bi;
    logic       fe;
    logic       pe;
    logic [7:0] data;
  } rx_entry_t;

  // Storage and state
  rx_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   err_cnt;
  logic [5:0]      tmo_cnt;
  logic            fifo_en_q;

  // Per-cycle control
  logic            mode_change;
  logic            do_clear;
  logic            empty;
  logic            full;
  logic            do_rd;
  logic            wr_store;
  logic            overwrite;
  logic            overrun_set;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            new_err;
  logic            head_err;
  logic            err_inc;
  logic            err_dec;
  rx_entry_t       head;
  rx_entry_t       wr_entry;

  // Character timeout
  logic [3:0]      frame_bits;
  logic [5:0]      tmo_limit;
  logic            tmo_clr;

  // Trigger level
  logic [4:0]      trig_level;

  // In holding mode the effective depth is 1, so the pointers stay pinned at 0.
  // This makes an overwrite land on the head entry.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p, input logic fifo_mode);
    ptr_next = fifo_mode ? (p + 1'b1) : '0;
  endfunction

  // Switching between FIFO and holding mode flushes the buffer. A flush wins over
  // any load or read in the same cycle.
  assign mode_change = fifo_en ^ fifo_en_q;
  assign do_clear    = fifo_clear | mode_change;

  assign empty = (count == '0);
  assign full  = fifo_en ? (count == DEPTH_C) : (count == ONE_C);

  assign head = mem[rd_ptr];

  // A break character is stored with zero data.
  always_comb begin
    wr_entry      = '0;
    wr_entry.bi   = uart_break;
    wr_entry.fe   = frame_error;
    wr_entry.pe   = parity_error;
    wr_entry.data = uart_break ? 8'h00 : rsr_data;
  end

  assign do_rd = rbr_rd & ~empty & ~do_clear;

  // A read in the same cycle frees the slot, so a load into a full buffer is still
  // accepted. Holding mode always accepts the load, overwriting the entry when full.
  assign wr_store    = receive_load_en & ~do_clear & (~full | do_rd | ~fifo_en);
  assign overwrite   = receive_load_en & ~do_clear & full & ~do_rd & ~fifo_en;
  assign overrun_set = receive_load_en & ~do_clear & full & ~do_rd;

  assign cnt_inc = wr_store & ~do_rd & ~overwrite;
  assign cnt_dec = do_rd & ~wr_store;

  // Error bookkeeping. An overwrite removes the old head, so its flags leave the
  // count as the new character's flags enter it.
  assign new_err  = uart_break | frame_error | parity_error;
  assign head_err = head.bi | head.fe | head.pe;
  assign err_inc  = wr_store & new_err;
  assign err_dec  = (do_rd | overwrite) & head_err;

  // Storage array. Contents are not reset because empty entries are masked at
  // the outputs.
  always_ff @(posedge pclk) begin
    if (wr_store) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge pclk) begin
    if (utrrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_cnt   <= '0;
      fifo_en_q <= fifo_en;
    end else begin
      fifo_en_q <= fifo_en;
      if (do_clear) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        err_cnt <= '0;
      end else begin
        if (wr_store && !overwrite) begin
          wr_ptr <= ptr_next(wr_ptr, fifo_en);
        end
        if (do_rd) begin
          rd_ptr <= ptr_next(rd_ptr, fifo_en);
        end
        if (cnt_inc) begin
          count <= count + ONE_C;
        end else if (cnt_dec) begin
          count <= count - ONE_C;
        end
        if (err_inc && !err_dec) begin
          err_cnt <= err_cnt + ONE_C;
        end else if (err_dec && !err_inc) begin
          err_cnt <= err_cnt - ONE_C;
        end
      end
    end
  end

  // Overrun is sticky. Only reset or an LSR read clears it, and a new overrun in
  // the same cycle as the LSR read keeps it set.
  always_ff @(posedge pclk) begin
    if (utrrst) begin
      overrun_error <= 1'b0;
    end else if (overrun_set) begin
      overrun_error <= 1'b1;
    end else if (lsr_rd) begin
      overrun_error <= 1'b0;
    end
  end

  // Timeout limit is four character times: start + data + parity + stop bits.
  assign frame_bits = 4'd7 + 4'(wls) + 4'(pen) + 4'(stb);
  assign tmo_limit  = {frame_bits, 2'b00};

  assign tmo_clr = receive_load_en | rbr_rd | empty | ~fifo_en | do_clear;

  // The counter saturates at the limit so char_timeout holds until activity clears it.
  always_ff @(posedge pclk) begin
    if (utrrst) begin
      tmo_cnt <= '0;
    end else if (tmo_clr) begin
      tmo_cnt <= '0;
    end else if (bit_tick && (tmo_cnt < tmo_limit)) begin
      tmo_cnt <= tmo_cnt + 6'd1;
    end
  end

  assign char_timeout = fifo_en & ~empty & (tmo_cnt >= tmo_limit);

  always_comb begin
    trig_level = 5'd1;
    case (rx_trigger)
      2'b00:   trig_level = 5'd1;
      2'b01:   trig_level = 5'd4;
      2'b10:   trig_level = 5'd8;
      default: trig_level = 5'd14;
    endcase
  end

  assign rx_trigger_hit = fifo_en ? (32'(count) >= 32'(trig_level)) : ~empty;

  // Head outputs are masked so an empty buffer always reads as zero.
  assign rbr_data      = empty ? 8'h00 : head.data;
  assign lsr_pe        = ~empty & head.pe;
  assign lsr_fe        = ~empty & head.fe;
  assign lsr_bi        = ~empty & head.bi;
  assign data_ready    = ~empty;
  assign rx_fifo_error = (err_cnt != '0);
  assign rx_fifo_count = count;

endmodule
